// File: rtl/whirlpool_wcipher_core.sv
// whirlpool_wcipher_core
// Iterative Whirlpool W block cipher. One full round is computed per clock.
// The key schedule and the data path each have their own Gamma/Pi/Theta
// instance. The state path consumes the round key produced in the same cycle.
// Byte n of a 512-bit block occupies bits [8n : 8n+7], MSB first. The matrix
// element at (row r, col c) is byte 8r+c.

module whirlpool_wcipher_core (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [0:511] i_key,
    input  logic [0:511] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [0:511] o_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } fsm_t;

    fsm_t         fsm_r;
    fsm_t         fsm_next_s;
    logic [3:0]   rnd_r;
    logic [0:511] key_r;
    logic [0:511] state_r;
    logic [0:511] key_next_s;
    logic [0:511] state_next_s;

    // Mini-box E of the S-box construction.
    function automatic logic [3:0] mini_e(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h1;  4'h1: y = 4'hB;  4'h2: y = 4'h9;  4'h3: y = 4'hC;
            4'h4: y = 4'hD;  4'h5: y = 4'h6;  4'h6: y = 4'hF;  4'h7: y = 4'h3;
            4'h8: y = 4'hE;  4'h9: y = 4'h8;  4'hA: y = 4'h7;  4'hB: y = 4'h4;
            4'hC: y = 4'hA;  4'hD: y = 4'h2;  4'hE: y = 4'h5;  4'hF: y = 4'h0;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // Inverse of mini-box E.
    function automatic logic [3:0] mini_einv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hF;  4'h1: y = 4'h0;  4'h2: y = 4'hD;  4'h3: y = 4'h7;
            4'h4: y = 4'hB;  4'h5: y = 4'hE;  4'h6: y = 4'h5;  4'h7: y = 4'hA;
            4'h8: y = 4'h9;  4'h9: y = 4'h2;  4'hA: y = 4'hC;  4'hB: y = 4'h1;
            4'hC: y = 4'h3;  4'hD: y = 4'h4;  4'hE: y = 4'h8;  4'hF: y = 4'h6;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // Mini-box R, the randomly chosen middle layer.
    function automatic logic [3:0] mini_r(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h7;  4'h1: y = 4'hC;  4'h2: y = 4'hB;  4'h3: y = 4'hD;
            4'h4: y = 4'hE;  4'h5: y = 4'h4;  4'h6: y = 4'h9;  4'h7: y = 4'hF;
            4'h8: y = 4'h6;  4'h9: y = 4'h3;  4'hA: y = 4'h8;  4'hB: y = 4'hA;
            4'hC: y = 4'h2;  4'hD: y = 4'h5;  4'hE: y = 4'h1;  4'hF: y = 4'h0;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // Gamma S-box, built from the E / E^-1 / R mini-boxes.
    function automatic logic [7:0] sbox(input logic [7:0] u);
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        a = mini_e(u[7:4]);
        b = mini_einv(u[3:0]);
        r = mini_r(a ^ b);
        return {mini_e(a ^ r), mini_einv(b ^ r)};
    endfunction

    // GF(2^8) multiply (polynomial 0x11D) by a small constant of at most 4 bits.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) begin
                acc = acc ^ p;
            end else begin
                acc = acc;
            end
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1d : 8'h00);
        end
        return acc;
    endfunction

    // First row of the circulant Theta matrix cir(1,1,4,1,8,5,2,9).
    function automatic logic [3:0] theta_coef(input logic [2:0] idx);
        logic [3:0] y;
        case (idx)
            3'd0: y = 4'd1;  3'd1: y = 4'd1;  3'd2: y = 4'd4;  3'd3: y = 4'd1;
            3'd4: y = 4'd8;  3'd5: y = 4'd5;  3'd6: y = 4'd2;  3'd7: y = 4'd9;
            default: y = 4'd0;
        endcase
        return y;
    endfunction

    // Row 0 of round constant c^r. Unreachable round values give zero.
    function automatic logic [63:0] rc_row(input logic [3:0] r);
        logic [63:0] y;
        case (r)
            4'd1:    y = 64'h1823c6e887b8014f;
            4'd2:    y = 64'h36a6d2f5796f9152;
            4'd3:    y = 64'h60bc9b8ea30c7b35;
            4'd4:    y = 64'h1de0d7c22e4bfe57;
            4'd5:    y = 64'h157737e59ff04ada;
            4'd6:    y = 64'h58c9290ab1a06b85;
            4'd7:    y = 64'hbd5d10f4cb3e0567;
            4'd8:    y = 64'he427418ba77d95d8;
            4'd9:    y = 64'hfbee7c66dd17479e;
            4'd10:   y = 64'hca2dbf07ad5a8333;
            default: y = 64'h0;
        endcase
        return y;
    endfunction

    // rho[k](x) = theta(pi(gamma(x))) ^ k.
    function automatic logic [0:511] rho(input logic [0:511] x, input logic [0:511] k);
        logic [7:0]   g [0:63];
        logic [7:0]   p [0:63];
        logic [7:0]   acc;
        logic [0:511] y;
        y = 512'h0;
        for (int n = 0; n < 64; n++) begin
            g[n] = sbox(x[8*n +: 8]);
        end
        // Pi: column c rotates down by c rows.
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                p[8*r + c] = g[8*((r - c) & 7) + c];
            end
        end
        // Theta: each row is multiplied by the circulant matrix.
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < 8; j++) begin
                acc = 8'h00;
                for (int kk = 0; kk < 8; kk++) begin
                    acc = acc ^ gmul(p[8*r + kk], theta_coef(3'((j - kk) & 7)));
                end
                y[8*(8*r + j) +: 8] = acc ^ k[8*(8*r + j) +: 8];
            end
        end
        return y;
    endfunction

    // The key path and state path are chained in the same cycle.
    // The state path uses K^r, not K^{r-1}.
    always_comb begin
        key_next_s   = rho(key_r, {rc_row(rnd_r), 448'h0});
        state_next_s = rho(state_r, key_next_s);
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fsm_r <= ST_IDLE;
        end else begin
            fsm_r <= fsm_next_s;
        end
    end

    // FSM next-state decode. An unknown encoding falls back to IDLE.
    always_comb begin
        fsm_next_s = ST_IDLE;
        case (fsm_r)
            ST_IDLE: begin
                if (i_valid) begin
                    fsm_next_s = ST_ROUND;
                end else begin
                    fsm_next_s = ST_IDLE;
                end
            end
            ST_ROUND: begin
                if (rnd_r >= 4'd10) begin
                    fsm_next_s = ST_DONE;
                end else begin
                    fsm_next_s = ST_ROUND;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    fsm_next_s = ST_IDLE;
                end else begin
                    fsm_next_s = ST_DONE;
                end
            end
            default: fsm_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode. Ready is held low while reset is asserted.
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (fsm_r)
            ST_IDLE:  o_ready = ~i_rst;
            ST_DONE:  o_valid = 1'b1;
            default: begin
                o_ready = 1'b0;
                o_valid = 1'b0;
            end
        endcase
    end

    // Key/state/round-counter datapath: load on accept, then one round per cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            key_r   <= 512'h0;
            state_r <= 512'h0;
            rnd_r   <= 4'd0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (i_valid) begin
                        key_r   <= i_key;
                        state_r <= i_data ^ i_key;
                        rnd_r   <= 4'd1;
                    end
                end
                ST_ROUND: begin
                    key_r   <= key_next_s;
                    state_r <= state_next_s;
                    if (rnd_r < 4'd10) begin
                        rnd_r <= rnd_r + 4'd1;
                    end
                end
                default: begin
                    rnd_r <= rnd_r;
                end
            endcase
        end
    end

    assign o_data = state_r;

endmodule

// File: tb/tb_whirlpool_wcipher_core.sv
// Self-checking bench for whirlpool_wcipher_core: directed vector table,
// hand-written multi-cycle sequences, and randomized runs against a
// software W-cipher model.

module tb_whirlpool_wcipher_core;

    logic         i_clk;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [0:511] i_key;
    logic [0:511] i_data;
    logic         o_valid;
    logic         i_ready;
    logic [0:511] o_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [0:255];

    localparam logic [0:511] KAT_DATA = {8'h80, 504'h0};
    localparam logic [0:511] KAT_OUT  = 512'h99fa61d75522a4669b44e39c1d2e1726c530232130d407f89afee0964997f7a73e83be698b288febcf88e3e03c4f0757ea8964e59b63d93708b138cc42a66eb3;

    typedef struct {
        logic [0:511] key;
        logic [0:511] data;
        logic [0:511] exp;
        int           bp;
        bit           busy;
        string        nm;
    } vec_t;

    vec_t vecs [0:5];

    whirlpool_wcipher_core dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_key   (i_key),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk_blk(input string nm, input logic [0:511] act, input logic [0:511] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // S-box from the mini-box tables; E^-1 found by searching E.
    task automatic build_sbox();
        logic [3:0] e [0:15];
        logic [3:0] r [0:15];
        logic [3:0] ei [0:15];
        logic [3:0] a, b, t;
        e = '{4'h1, 4'hB, 4'h9, 4'hC, 4'hD, 4'h6, 4'hF, 4'h3,
              4'hE, 4'h8, 4'h7, 4'h4, 4'hA, 4'h2, 4'h5, 4'h0};
        r = '{4'h7, 4'hC, 4'hB, 4'hD, 4'hE, 4'h4, 4'h9, 4'hF,
              4'h6, 4'h3, 4'h8, 4'hA, 4'h2, 4'h5, 4'h1, 4'h0};
        for (int i = 0; i < 16; i++) ei[e[i]] = 4'(i);
        for (int u = 0; u < 256; u++) begin
            a = e[(u >> 4) & 15];
            b = ei[u & 15];
            t = r[a ^ b];
            sb[u] = {e[a ^ t], ei[b ^ t]};
        end
    endtask

    function automatic logic [7:0] mdl_mul(input logic [7:0] a, input int c);
        logic [7:0] acc = 8'h00;
        logic [7:0] p = a;
        for (int i = 0; i < 8; i++) begin
            if ((c >> i) & 1) acc ^= p;
            p = (p << 1) ^ ((p & 8'h80) != 8'h00 ? 8'h1d : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [0:511] mdl_rho(input logic [0:511] x, input logic [0:511] k);
        int cc [0:7] = '{1, 1, 4, 1, 8, 5, 2, 9};
        logic [7:0] m [0:7][0:7];
        logic [7:0] s [0:7][0:7];
        logic [7:0] v;
        logic [0:511] y;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                m[(i + j) % 8][j] = sb[x[64*i + 8*j +: 8]];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                v = 8'h00;
                for (int q = 0; q < 8; q++) v ^= mdl_mul(m[i][q], cc[(j + 8 - q) % 8]);
                s[i][j] = v;
            end
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                y[64*i + 8*j +: 8] = s[i][j] ^ k[64*i + 8*j +: 8];
        return y;
    endfunction

    function automatic logic [0:511] mdl_w(input logic [0:511] key, input logic [0:511] data);
        logic [0:511] kk = key;
        logic [0:511] st = key ^ data;
        logic [0:511] rc;
        for (int r = 1; r <= 10; r++) begin
            rc = 512'h0;
            for (int j = 0; j < 8; j++) rc[8*j +: 8] = sb[8*(r - 1) + j];
            kk = mdl_rho(kk, rc);
            st = mdl_rho(st, kk);
        end
        return st;
    endfunction

    function automatic logic [0:511] rand512();
        logic [0:511] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!o_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        chk_int({nm, "_ready"}, int'(o_ready), 1);
    endtask

    // One block: accept, optional busy pulses, latency, back-pressure, handoff.
    task automatic run_one(input logic [0:511] k, input logic [0:511] d,
                           input logic [0:511] exp, input int bp, input bit busy,
                           input string nm);
        int lat;
        wait_ready(nm);
        i_key   = k;
        i_data  = d;
        i_valid = 1'b1;
        i_ready = (bp == 0);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_key   = rand512();
        i_data  = rand512();
        lat = 0;
        while (!o_valid && lat < 30) begin
            chk_int({nm, "_busy_ready"}, int'(o_ready), 0);
            if (busy) begin
                i_valid = 1'b1;
                i_key   = rand512();
                i_data  = rand512();
            end
            @(negedge i_clk);
            lat++;
        end
        i_valid = 1'b0;
        chk_int({nm, "_latency"}, lat, 10);
        chk_blk({nm, "_data"}, o_data, exp);
        for (int i = 0; i < bp; i++) begin
            @(negedge i_clk);
            chk_int({nm, "_hold_valid"}, int'(o_valid), 1);
            chk_blk({nm, "_hold_data"}, o_data, exp);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        chk_int({nm, "_post_valid"}, int'(o_valid), 0);
        chk_int({nm, "_post_ready"}, int'(o_ready), 1);
        i_ready = 1'b0;
    endtask

    initial begin
        logic [0:511] c2;
        logic [0:511] rk;
        logic [0:511] rd;

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_key   = 512'h0;
        i_data  = 512'h0;
        build_sbox();

        vecs[0] = '{512'h0, KAT_DATA, KAT_OUT, 0, 1'b0, "kat"};
        vecs[1] = '{512'h0, KAT_DATA, KAT_OUT, 7, 1'b0, "kat_bp7"};
        vecs[2] = '{512'h0, KAT_DATA, KAT_OUT, 0, 1'b1, "kat_busy"};
        vecs[3] = '{{64{8'hff}}, 512'h0, 512'h0, 2, 1'b0, "ones_key"};
        vecs[4] = '{512'h0, 512'h0, 512'h0, 1, 1'b1, "zero"};
        vecs[5] = '{KAT_OUT, KAT_DATA, 512'h0, 0, 1'b0, "chain"};
        for (int i = 0; i < 64; i++) vecs[4].data[8*i +: 8] = 8'(i);
        for (int i = 3; i < 6; i++) vecs[i].exp = mdl_w(vecs[i].key, vecs[i].data);

        // Reset state.
        #3;
        chk_int("rst_ready", int'(o_ready), 0);
        chk_int("rst_valid", int'(o_valid), 0);
        chk_blk("rst_data", o_data, 512'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk_int("rel_ready", int'(o_ready), 1);

        // Directed table.
        for (int i = 0; i < 6; i++)
            run_one(vecs[i].key, vecs[i].data, vecs[i].exp, vecs[i].bp, vecs[i].busy, vecs[i].nm);

        // Back-to-back with i_valid held high.
        c2 = mdl_w(KAT_OUT, KAT_DATA);
        wait_ready("b2b");
        i_key   = 512'h0;
        i_data  = KAT_DATA;
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_key = KAT_OUT;
        for (int n = 1; n <= 11; n++) begin
            @(negedge i_clk);
            if (n == 10) begin
                chk_int("b2b_v1", int'(o_valid), 1);
                chk_blk("b2b_d1", o_data, KAT_OUT);
            end
            if (n == 11) chk_int("b2b_idle", int'(o_ready), 1);
        end
        @(negedge i_clk);
        chk_int("b2b_accept12", int'(o_ready), 0);
        i_valid = 1'b0;
        for (int n = 1; n <= 10; n++) @(negedge i_clk);
        chk_int("b2b_v2", int'(o_valid), 1);
        chk_blk("b2b_d2", o_data, c2);
        @(negedge i_clk);
        chk_int("b2b_v2_done", int'(o_valid), 0);
        i_ready = 1'b0;

        // Asynchronous reset around round 5.
        wait_ready("abort");
        i_key   = 512'h0;
        i_data  = KAT_DATA;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (4) @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        chk_int("abort_ready", int'(o_ready), 0);
        chk_int("abort_valid", int'(o_valid), 0);
        chk_blk("abort_data", o_data, 512'h0);
        @(negedge i_clk);
        chk_int("abort_hold_valid", int'(o_valid), 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk_int("abort_rel_ready", int'(o_ready), 1);
        chk_int("abort_rel_valid", int'(o_valid), 0);
        run_one(512'h0, KAT_DATA, KAT_OUT, 0, 1'b0, "kat_after_abort");

        // Randomized blocks with random gaps and back-pressure.
        for (int t = 0; t < 1000; t++) begin
            rk = rand512();
            rd = rand512();
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
            run_one(rk, rd, mdl_w(rk, rd), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
